hazard_ctrl: RTL

//   Pipeline hazard controller for the 5-stage core. Drives the stall/flush

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing, EX operand forwarding and MDU hold FSM.
// Optional branch-operand forwarding and branch stall are built when HAZ_BRANCH_FWD_EN is defined.
module hazard_ctrl #(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic [4:0] Rs_E,
    input  logic [4:0] Rt_E,
    input  logic [4:0] WriteReg_E,
    input  logic [4:0] WriteReg_M,
    input  logic [4:0] WriteReg_W,
    input  logic       MemToReg_E,
    input  logic       RegWrite_E,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic       PCSrc_D,
    input  logic       MduStart_E,
`ifdef HAZ_BRANCH_FWD_EN
    input  logic       Branch_D,
    input  logic       MemToReg_M,
    output logic       ForwardA_D,
    output logic       ForwardB_D,
`endif
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       MduBusy
);

    typedef enum logic [1:0] {StRun, StMduBusy, StMduDone} state_t;

    state_t             state_q, state_d;
    logic   [CNT_W-1:0] cnt_q, cnt_d;
    logic               mdu_stall;
    logic               lwstall;
    logic               branchstall;
    logic               dep_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (RegWrite_M && (WriteReg_M != 5'd0) && (WriteReg_M == src)) begin
            return 2'b10;
        end else if (RegWrite_W && (WriteReg_W != 5'd0) && (WriteReg_W == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The RUN cycle that sees MduStart_E is stall 1; BUSY covers the remaining LATENCY-1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        unique case (state_q)
            StRun: begin
                if (MduStart_E) begin
                    mdu_stall = 1'b1;
                    state_d   = StMduBusy;
                    cnt_d     = CNT_W'(MDU_LATENCY - 1);
                end
            end
            StMduBusy: begin
                mdu_stall = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StMduDone;
                    cnt_d   = '0;
                end
            end
            StMduDone: begin
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        lwstall = MemToReg_E && (WriteReg_E != 5'd0) &&
                  ((WriteReg_E == Rs_D) || (WriteReg_E == Rt_D));
    end

`ifdef HAZ_BRANCH_FWD_EN
    always_comb begin
        branchstall = Branch_D &&
            ((RegWrite_E && (WriteReg_E != 5'd0) &&
              ((WriteReg_E == Rs_D) || (WriteReg_E == Rt_D))) ||
             (MemToReg_M && (WriteReg_M != 5'd0) &&
              ((WriteReg_M == Rs_D) || (WriteReg_M == Rt_D))));
        ForwardA_D  = RegWrite_M && (WriteReg_M != 5'd0) && (WriteReg_M == Rs_D);
        ForwardB_D  = RegWrite_M && (WriteReg_M != 5'd0) && (WriteReg_M == Rt_D);
    end
`else
    logic unused_regwrite_e;
    assign unused_regwrite_e = RegWrite_E;
    assign branchstall       = 1'b0;
`endif

    // Data-dependency stalls are only evaluated outside the MDU hold.
    always_comb begin
        dep_stall  = (state_q != StMduBusy) && (lwstall || branchstall);
        StallE     = mdu_stall;
        FlushM     = mdu_stall;
        StallF     = mdu_stall | dep_stall;
        StallD     = mdu_stall | dep_stall;
        FlushE     = dep_stall & ~StallE;
        FlushD     = PCSrc_D & ~StallD;
        ForwardA_E = fwd_sel(Rs_E);
        ForwardB_E = fwd_sel(Rt_E);
        MduBusy    = (state_q == StMduBusy);
    end

endmodule
